output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Round-robin arbiter and packet serializer for one router output port. It shares the port among N input buffers that each present queued 4-byte packets. It pops one packet from the winning buffer and replays it as a contiguous 4-cycle byte burst on a put/payload interface. That interface is the same one the downstream input buffer consumes.

## Interface
- N, 4, number of requesting input buffers
- PKT_BYTES, 4, bytes per packet (fixed at 4; other values are not supported)
- clock  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- req_avail  input  N  bit i high: buffer i has a packet at its queue head
- pkt_in  input  N*32  packet at head of buffer i in bits [32i+31:32i]; byte 0 = bits [32i+31:32i+24], sent first
- out_full  input  1  downstream queue full; start no packet while high
- read  output  N  one-hot, single-cycle pop strobe to the granted buffer
- grant  output  N  one-hot owner of the port for the current packet; 0 when idle
- put  output  1  payload byte valid
- payload  output  8  byte being transferred
- busy  output  1  high from the grant cycle through the GAP cycle

## Operation
- States: IDLE, SEND0, SEND1, SEND2, SEND3, GAP.
- IDLE: if any req_avail bit is high and out_full is low, select a winner by round-robin.
  - Search order: last+1, last+2, … mod N, where last is the previously granted index.
  - Same cycle, combinationally: assert read[win] and grant[win]. grant[win] is a pointer into pkt_in and is valid only in this IDLE cycle, so the capture below is defined in terms of it.
  - At the clock edge: capture pkt_in for the winner into a 32-bit shift register, set last = win, go to SEND0.
- Source buffers are first-word-fall-through: pkt_in for buffer i is valid whenever req_avail[i] is high. The block samples it in the read cycle.
- SENDk (k = 0..3): put = 1, payload = byte k of the captured packet, grant held. Always advance to the next state. No stall is possible mid-packet.
- GAP: put = 0 for exactly one cycle, then go to IDLE. The downstream delimits packets by put deassertion, so bursts are never back-to-back.
- out_full and req_avail are sampled only in IDLE. Changes during SEND/GAP are ignored.
- last is an index of width ceil(log2 N). Wrap from N-1 to 0 uses the mod N arithmetic.
- busy = 1 whenever state ≠ IDLE, and also in the IDLE cycle where a grant is issued.

## Timing
- Reset values:
  - read = 0, grant = 0, put = 0, payload = 0x00, busy = 0.
  - State = IDLE, last = N-1, so buffer 0 has first priority.
- read and grant in IDLE are Mealy outputs. put, payload and grant during SEND/GAP come from registered state.
- Grant cycle T (read pulse):
  - T+1..T+4: put = 1 with bytes 0, 1, 2, 3.
  - T+5: GAP.
  - T+6: earliest next grant.
- Sustained throughput is one packet per 6 cycles.
- payload returns to 0x00 whenever put = 0.
- No request, or out_full high in IDLE: no read, stay in IDLE, last unchanged.
- Simultaneous requests: exactly one read bit is set; never two.
- Reset asserted mid-burst:
  - put, read and grant drop asynchronously.
  - The partial packet is abandoned and not re-sent.
  - last returns to N-1.
- A buffer whose req_avail is high gets a grant within N grant opportunities.

## Test plan
- Reset, then req_avail = 0001 and pkt_in[0] = 0xA1B2C3D4 → read = 0001 for 1 cycle; next 4 cycles put = 1, payload A1, B2, C3, D4; then put = 0 for 1 cycle.
- req_avail = 1111 held continuously → grants in order 0, 1, 2, 3, 0; read pulses exactly 6 cycles apart.
- last = 2, req_avail = 1011 → next grant is 3, then 0, then 1; buffer 2 is skipped.
- out_full = 1 with req_avail = 0100 → no read for 10 cycles. Drop out_full → read = 0100 in that same cycle.
- out_full raised during SEND1 → remaining bytes still sent; no new grant until out_full is low in IDLE.
- reset_n pulsed low during SEND2 → put = 0 immediately. After release with req_avail = 0010 → grant 1; the first byte out is byte 0 of the new packet.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter and packet serializer for one router output port.
// Pops one 4-byte packet from the winning input buffer and replays it as a 4-cycle byte burst.
module output_port_arbiter #(
    parameter int N         = 4,
    parameter int PKT_BYTES = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N-1:0]               req_avail,
    input  logic [N*PKT_BYTES*8-1:0]   pkt_in,
    input  logic                       out_full,
    output logic [N-1:0]               read,
    output logic [N-1:0]               grant,
    output logic                       put,
    output logic [7:0]                 payload,
    output logic                       busy
);

    localparam int PKT_BITS = PKT_BYTES * 8;
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND0,
        SEND1,
        SEND2,
        SEND3,
        GAP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [N-1:0]         win_onehot;
    logic [PKT_BITS-1:0]  win_pkt;
    logic [N-1:0]         owner;
    logic [PKT_BITS-1:0]  shreg;
    logic                 grant_now;
    int                   cand;

    // Round-robin search starting just after the previous winner, wrapping mod N.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = last;
        cand      = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!win_found && req_avail[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign win_onehot = N'(1) << win_idx;
    assign win_pkt    = pkt_in[PKT_BITS*int'(win_idx) +: PKT_BITS];
    assign grant_now  = (state == IDLE) && win_found && !out_full;

    always_comb begin
        state_nxt = state;
        read      = '0;
        grant     = owner;
        put       = 1'b0;
        payload   = 8'h00;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                grant = '0;
                if (grant_now) begin
                    read      = win_onehot;
                    grant     = win_onehot;
                    busy      = 1'b1;
                    state_nxt = SEND0;
                end
            end
            SEND0, SEND1, SEND2: begin
                put       = 1'b1;
                payload   = shreg[PKT_BITS-1 -: 8];
                state_nxt = state_t'(state + 3'd1);
            end
            SEND3: begin
                put       = 1'b1;
                payload   = shreg[PKT_BITS-1 -: 8];
                state_nxt = GAP;
            end
            GAP: begin
                // One dead cycle so the downstream sees put drop between packets.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= IDX_W'(N - 1);
            shreg <= '0;
            owner <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state <= state_nxt;
            if (grant_now) begin
                shreg <= win_pkt;
                last  <= win_idx;
                owner <= win_onehot;
            end else if (put) begin
                shreg <= {shreg[PKT_BITS-9:0], 8'h00};
            end
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus random traffic,
// compared each cycle against a packet-level reference model.
module tb_output_port_arbiter;

    localparam int N = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_avail;
    logic [N*32-1:0]  pkt_in;
    logic             out_full;
    logic [N-1:0]     read;
    logic [N-1:0]     grant;
    logic             put;
    logic [7:0]       payload;
    logic             busy;

    output_port_arbiter #(.N(N), .PKT_BYTES(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_avail (req_avail),
        .pkt_in    (pkt_in),
        .out_full  (out_full),
        .read      (read),
        .grant     (grant),
        .put       (put),
        .payload   (payload),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Reference model: previous winner, cycles since the last grant (-1 = port free), packet bytes.
    int         m_last;
    int         m_since;
    int         m_owner;
    logic [7:0] m_bytes [4];

    int rd_idx[$];
    int rd_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick_winner();
        for (int i = 1; i <= N; i++) begin
            int c = (m_last + i) % N;
            if (req_avail[c]) return c;
        end
        return -1;
    endfunction

    function automatic int onehot_to_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_since = -1;
        m_owner = 0;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int             w;
        logic [N-1:0]   e_read;
        logic [N-1:0]   e_grant;
        logic           e_put;
        logic [7:0]     e_pay;
        logic           e_busy;
        bit             chk_grant;
        #1;
        w         = (m_since < 0 && !out_full) ? pick_winner() : -1;
        e_read    = '0;
        e_grant   = '0;
        e_put     = 1'b0;
        e_pay     = 8'h00;
        e_busy    = 1'b0;
        chk_grant = 1'b1;
        if (m_since < 0) begin
            if (w >= 0) begin
                e_read  = N'(1) << w;
                e_grant = e_read;
                e_busy  = 1'b1;
            end
        end else if (m_since < 4) begin
            e_grant = N'(1) << m_owner;
            e_put   = 1'b1;
            e_pay   = m_bytes[m_since];
            e_busy  = 1'b1;
        end else begin
            e_busy    = 1'b1;
            chk_grant = 1'b0;
        end
        check("read", 32'(read), 32'(e_read));
        check("put", 32'(put), 32'(e_put));
        check("payload", 32'(payload), 32'(e_pay));
        check("busy", 32'(busy), 32'(e_busy));
        if (chk_grant) check("grant", 32'(grant), 32'(e_grant));
        if (read != '0) begin
            rd_idx.push_back(onehot_to_idx(read));
            rd_cyc.push_back(cyc);
        end
        if (w >= 0) begin
            for (int k = 0; k < 4; k++) m_bytes[k] = pkt_in[32*w + 31 - 8*k -: 8];
        end
        @(posedge clock);
        if (w >= 0) begin
            m_last  = w;
            m_owner = w;
            m_since = 0;
        end else if (m_since >= 0) begin
            m_since = (m_since == 4) ? -1 : m_since + 1;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Entered shortly after a falling edge; leaves at a falling edge with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_read", 32'(read), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_put", 32'(put), 32'h0);
        check("rst_payload", 32'(payload), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic clear_log();
        rd_idx.delete();
        rd_cyc.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_avail = '0;
        pkt_in    = '0;
        out_full  = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        do_reset();

        // Single packet from buffer 0.
        clear_log();
        req_avail = 4'b0001;
        pkt_in    = {96'h0, 32'hA1B2C3D4};
        cycle();
        req_avail = 4'b0000;
        run(6);
        check("t1_reads", 32'(rd_idx.size()), 32'd1);
        if (rd_idx.size() == 1) check("t1_idx", 32'(rd_idx[0]), 32'd0);

        // All four requesting: strict rotation, one grant every 6 cycles.
        do_reset();
        clear_log();
        req_avail = 4'b1111;
        pkt_in    = {$urandom, $urandom, $urandom, $urandom};
        run(26);
        check("t2_reads", 32'(rd_idx.size()), 32'd5);
        if (rd_idx.size() == 5) begin
            int exp_order[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) check("t2_order", 32'(rd_idx[i]), 32'(exp_order[i]));
            for (int i = 1; i < 5; i++) check("t2_spacing", 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd6);
        end
        req_avail = '0;
        run(6);

        // last = 2, then 1011 requesting: 3, 0, 1, skipping 2.
        do_reset();
        req_avail = 4'b0100;
        cycle();
        req_avail = 4'b0000;
        run(5);
        clear_log();
        req_avail = 4'b1011;
        pkt_in    = {$urandom, $urandom, $urandom, $urandom};
        run(14);
        check("t3_reads", 32'(rd_idx.size()), 32'd3);
        if (rd_idx.size() == 3) begin
            check("t3_first", 32'(rd_idx[0]), 32'd3);
            check("t3_second", 32'(rd_idx[1]), 32'd0);
            check("t3_third", 32'(rd_idx[2]), 32'd1);
        end
        req_avail = '0;
        run(6);

        // out_full blocks grants; grant appears in the same cycle it drops.
        clear_log();
        req_avail = 4'b0100;
        out_full  = 1'b1;
        run(10);
        check("t4_blocked", 32'(rd_idx.size()), 32'd0);
        out_full = 1'b0;
        cycle();
        check("t4_released", 32'(rd_idx.size()), 32'd1);
        if (rd_idx.size() == 1) check("t4_idx", 32'(rd_idx[0]), 32'd2);
        req_avail = '0;
        run(5);

        // out_full raised mid-burst: burst completes, then no grant until it drops.
        clear_log();
        req_avail = 4'b0001;
        pkt_in    = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        cycle();
        out_full  = 1'b1;
        req_avail = 4'b1111;
        run(8);
        check("t5_held", 32'(rd_idx.size()), 32'd1);
        out_full = 1'b0;
        cycle();
        check("t5_resume", 32'(rd_idx.size()), 32'd2);
        req_avail = '0;
        run(6);

        // Reset during SEND2: put drops at once; next packet starts from byte 0.
        req_avail = 4'b0001;
        pkt_in    = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        req_avail = 4'b0000;
        cycle();
        cycle();
        #1;
        check("t6_put_before", 32'(put), 32'd1);
        do_reset();
        clear_log();
        req_avail = 4'b0010;
        pkt_in    = {32'h0, 32'h0, 32'h5566_7788, 32'h0};
        cycle();
        req_avail = 4'b0000;
        run(5);
        check("t6_reads", 32'(rd_idx.size()), 32'd1);
        if (rd_idx.size() == 1) check("t6_idx", 32'(rd_idx[0]), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req_avail = N'($urandom);
            out_full  = ($urandom_range(0, 4) == 0);
            pkt_in    = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
